// File: rtl/fetch_pkg.sv
// Shared widths, constants and types for the instruction fetch sequencer.
package fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int INST_W = 8;
    localparam logic [INST_W-1:0] HALT_INST  = 8'hFF;
    localparam logic [ADDR_W-1:0] START_ADDR = 8'h00;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_e;
endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational ROM and holds one valid/ready slot for decode.
// Optional accepted-instruction counter is built only when FETCH_COUNT_EN is defined.
module inst_fetch_ctrl
    import fetch_pkg::fetch_state_e;
    import fetch_pkg::IDLE;
    import fetch_pkg::RUN;
    import fetch_pkg::HALTED;
#(
    parameter int                 ADDR_W     = fetch_pkg::ADDR_W,
    parameter int                 INST_W     = fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0]  START_ADDR = fetch_pkg::START_ADDR,
    parameter logic [INST_W-1:0]  HALT_INST  = fetch_pkg::HALT_INST
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              halted_o,
    output logic [15:0]       fetch_count_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              vld_q, vld_d;
    logic              slot_free, drain;

    assign slot_free = !vld_q || inst_ready_i;
    assign drain     = vld_q && inst_ready_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pc_d    = START_ADDR;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_i) begin
                    pc_d  = redirect_addr_i;
                    vld_d = 1'b0;
                end else if (slot_free) begin
                    // The halt word is swallowed: the slot empties and pc stays on it.
                    if (rom_data_i == HALT_INST) begin
                        vld_d   = 1'b0;
                        state_d = HALTED;
                    end else begin
                        inst_d = rom_data_i;
                        ipc_d  = pc_q;
                        vld_d  = 1'b1;
                        pc_d   = pc_q + ADDR_W'(1);
                    end
                end
            end
            HALTED: begin
                if (drain) vld_d = 1'b0;
                if (redirect_i) begin
                    pc_d    = redirect_addr_i;
                    vld_d   = 1'b0;
                    state_d = RUN;
                end else if (start_i) begin
                    pc_d    = START_ADDR;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            inst_q  <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (drain && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count_o = count_q;
`else
    assign fetch_count_o = 16'h0000;
`endif

    assign rom_addr_o   = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = ipc_q;
    assign inst_valid_o = vld_q;
    assign halted_o     = (state_q == HALTED);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl against a 5-word ROM (addr 0..4 -> 0..4, else 0xFF).
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        halted;
    logic [15:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rom_data = (rom_addr <= 8'd4) ? rom_addr : 8'hFF;

    inst_fetch_ctrl dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .start_i         (start),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data),
        .inst_o          (inst),
        .inst_pc_o       (inst_pc),
        .inst_valid_o    (inst_valid),
        .inst_ready_i    (inst_ready),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .halted_o        (halted),
        .fetch_count_o   (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string tag, input logic [7:0] ei, input logic [7:0] ep);
        check({tag, " valid"}, 16'(inst_valid), 16'h1);
        check({tag, " inst"}, 16'(inst), 16'(ei));
        check({tag, " inst_pc"}, 16'(inst_pc), 16'(ep));
    endtask

    task automatic expect_halt(input string tag, input logic [7:0] ea);
        check({tag, " halted"}, 16'(halted), 16'h1);
        check({tag, " valid"}, 16'(inst_valid), 16'h0);
        check({tag, " rom_addr"}, 16'(rom_addr), 16'(ea));
    endtask

    initial begin
        logic [15:0] exp_cnt;

        // Reset state
        step();
        step();
        check("rst valid", 16'(inst_valid), 16'h0);
        check("rst halted", 16'(halted), 16'h0);
        check("rst inst", 16'(inst), 16'h0);
        check("rst inst_pc", 16'(inst_pc), 16'h0);
        check("rst rom_addr", 16'(rom_addr), 16'h0);
        check("rst count", fetch_count, 16'h0);

        // 1: start, stream 0..4, then halt without presenting 0xFF
        reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1 rom_addr", 16'(rom_addr), 16'h0);
        check("t1 valid0", 16'(inst_valid), 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_inst("t1", 8'(i), 8'(i));
        end
        step();
        expect_halt("t1", 8'h05);
`ifdef FETCH_COUNT_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        check("t1 count", fetch_count, exp_cnt);

        // 2: backpressure while 02 is presented
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2 restart halted", 16'(halted), 16'h0);
        step();
        check_inst("t2 a", 8'h00, 8'h00);
        step();
        check_inst("t2 b", 8'h01, 8'h01);
        step();
        check_inst("t2 c", 8'h02, 8'h02);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_inst("t2 hold", 8'h02, 8'h02);
            check("t2 hold pc", 16'(rom_addr), 16'h3);
        end
        inst_ready = 1'b1;
        step();
        check_inst("t2 resume", 8'h03, 8'h03);
        step();
        check_inst("t2 next", 8'h04, 8'h04);
        step();
        expect_halt("t2", 8'h05);

        // 3: redirect to 03 while 01 is valid
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_inst("t3 pre", 8'h01, 8'h01);
        redirect = 1'b1;
        redirect_addr = 8'h03;
        step();
        redirect = 1'b0;
        check("t3 flush valid", 16'(inst_valid), 16'h0);
        check("t3 new pc", 16'(rom_addr), 16'h3);
        step();
        check_inst("t3 target", 8'h03, 8'h03);
        step();
        check_inst("t3 next", 8'h04, 8'h04);
        step();
        expect_halt("t3", 8'h05);

        // 4: redirect out of HALTED to 01
        redirect = 1'b1;
        redirect_addr = 8'h01;
        step();
        redirect = 1'b0;
        check("t4 halted", 16'(halted), 16'h0);
        check("t4 valid", 16'(inst_valid), 16'h0);
        check("t4 pc", 16'(rom_addr), 16'h1);
        for (int i = 1; i < 5; i++) begin
            step();
            check_inst("t4", 8'(i), 8'(i));
        end
        step();
        expect_halt("t4", 8'h05);

        // 5: redirect onto the halt word at 0xFF, pc must not wrap
        redirect = 1'b1;
        redirect_addr = 8'hFF;
        step();
        redirect = 1'b0;
        check("t5 halted0", 16'(halted), 16'h0);
        check("t5 pc", 16'(rom_addr), 16'hFF);
        step();
        expect_halt("t5 a", 8'hFF);
        step();
        expect_halt("t5 b", 8'hFF);

        // 6: reset mid-stream, then IDLE ignores redirect and does not fetch
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_inst("t6 pre", 8'h01, 8'h01);
        reset_n = 1'b0;
        step();
        check("t6 valid", 16'(inst_valid), 16'h0);
        check("t6 halted", 16'(halted), 16'h0);
        check("t6 pc", 16'(rom_addr), 16'h0);
        check("t6 inst", 16'(inst), 16'h0);
        check("t6 count", fetch_count, 16'h0);
        reset_n = 1'b1;
        redirect = 1'b1;
        redirect_addr = 8'h03;
        step();
        redirect = 1'b0;
        check("t6 idle redirect pc", 16'(rom_addr), 16'h0);
        check("t6 idle valid", 16'(inst_valid), 16'h0);
        step();
        check("t6 idle nofetch", 16'(inst_valid), 16'h0);
        check("t6 idle halted", 16'(halted), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
